// File: rtl/vend_sequencer.sv
// vend_sequencer
// Central controller for the micro vending machine. It steps the goods
// selection, accepts coins up to a credit ceiling, releases the purchased
// item and then pays change out one denomination per pulse, largest first.
//
// Ports
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   btn_goods/confirm/change/cancel
//                             one-cycle debounced key pulses
//   coin_one..coin_fifty      one-cycle coin pulses (1, 5, 10, 20, 50)
//   need_money                price of the selected item, 0 when none
//   input_money               accumulated credit
//   change_money              change still owed
//   goods_sel                 selected item index
//   vend_pulse                one-cycle pulse, item goods_sel released
//   coin_reject               one-cycle pulse, a coin was refused
//   disp_valid / disp_denom   one-cycle dispense strobe and its denomination
//                             (0=1, 1=5, 2=10, 3=20, 4=50)
//   state_o                   current state encoding, for observation
//
// Handshake: every input and output here is a single-cycle strobe with no
// backpressure. A strobe is acted on at the clock edge that samples it, and
// each output strobe is high for exactly one cycle with its qualifying data
// (disp_denom, goods_sel) stable during that cycle. There is no ready side.
//
// All outputs come straight from registers.

module vend_sequencer #(
  parameter logic [7:0]  PRICE0     = 8'd3,
  parameter logic [7:0]  PRICE1     = 8'd5,
  parameter logic [7:0]  PRICE2     = 8'd12,
  parameter logic [7:0]  PRICE3     = 8'd25,
  parameter logic [7:0]  MAX_CREDIT = 8'd99,
  parameter logic [23:0] GAP        = 24'd4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_goods,
  input  logic       btn_confirm,
  input  logic       btn_change,
  input  logic       btn_cancel,
  input  logic       coin_one,
  input  logic       coin_five,
  input  logic       coin_ten,
  input  logic       coin_twenty,
  input  logic       coin_fifty,
  output logic [7:0] need_money,
  output logic [7:0] input_money,
  output logic [7:0] change_money,
  output logic [1:0] goods_sel,
  output logic       vend_pulse,
  output logic       coin_reject,
  output logic       disp_valid,
  output logic [2:0] disp_denom,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    PAY      = 3'd2,
    VEND     = 3'd3,
    DISPENSE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  need_nxt, input_nxt, change_nxt;
  logic [1:0]  sel_nxt;
  logic        vend_nxt, reject_nxt, disp_valid_nxt;
  logic [2:0]  disp_denom_nxt;
  logic [23:0] gap_cnt, gap_nxt;

  // Coin decode: only the highest denomination in a cycle is considered.
  logic [4:0]  coin_vec;
  logic        coin_any, coin_multi, coin_fits;
  logic [7:0]  coin_val;
  logic [8:0]  credit_sum;

  // Largest denomination that still fits into the owed change.
  logic [2:0]  pay_denom;
  logic [7:0]  pay_val;

  logic [1:0]  sel_step;

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  always_comb begin
    coin_vec = {coin_fifty, coin_twenty, coin_ten, coin_five, coin_one};
    coin_any = |coin_vec;
    // More than one bit set: clearing the lowest set bit leaves something.
    coin_multi = (coin_vec & (coin_vec - 5'd1)) != 5'd0;
    if (coin_fifty)       coin_val = 8'd50;
    else if (coin_twenty) coin_val = 8'd20;
    else if (coin_ten)    coin_val = 8'd10;
    else if (coin_five)   coin_val = 8'd5;
    else if (coin_one)    coin_val = 8'd1;
    else                  coin_val = 8'd0;
    // Nine-bit sum so the ceiling test cannot be fooled by a wrap.
    credit_sum = {1'b0, input_money} + {1'b0, coin_val};
    coin_fits  = credit_sum <= {1'b0, MAX_CREDIT};
  end

  always_comb begin
    if (change_money >= 8'd50) begin
      pay_denom = 3'd4;
      pay_val   = 8'd50;
    end else if (change_money >= 8'd20) begin
      pay_denom = 3'd3;
      pay_val   = 8'd20;
    end else if (change_money >= 8'd10) begin
      pay_denom = 3'd2;
      pay_val   = 8'd10;
    end else if (change_money >= 8'd5) begin
      pay_denom = 3'd1;
      pay_val   = 8'd5;
    end else begin
      pay_denom = 3'd0;
      pay_val   = 8'd1;
    end
  end

  assign sel_step = goods_sel + 2'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    need_nxt       = need_money;
    input_nxt      = input_money;
    change_nxt     = change_money;
    sel_nxt        = goods_sel;
    vend_nxt       = 1'b0;
    reject_nxt     = 1'b0;
    disp_valid_nxt = 1'b0;
    disp_denom_nxt = disp_denom;
    gap_nxt        = gap_cnt;

    case (state)
      IDLE: begin
        reject_nxt = coin_any;
        if (btn_goods) begin
          state_nxt = SELECT;
          sel_nxt   = 2'd0;
          need_nxt  = PRICE0;
        end
      end

      SELECT: begin
        reject_nxt = coin_any;
        if (btn_cancel) begin
          state_nxt = IDLE;
          need_nxt  = 8'd0;
          sel_nxt   = 2'd0;
        end else if (btn_confirm) begin
          state_nxt = PAY;
        end else if (btn_goods) begin
          sel_nxt  = sel_step;
          need_nxt = price_of(sel_step);
        end
      end

      PAY: begin
        if (btn_cancel) begin
          // Refund everything through the normal dispense path.
          state_nxt  = DISPENSE;
          change_nxt = input_money;
          input_nxt  = 8'd0;
          need_nxt   = 8'd0;
          gap_nxt    = 24'd0;
          reject_nxt = coin_any;
        end else if (btn_change && (input_money >= need_money)) begin
          // The purchase is settled on entry to VEND so the release pulse
          // and the owed change appear together.
          state_nxt  = VEND;
          vend_nxt   = 1'b1;
          change_nxt = input_money - need_money;
          input_nxt  = 8'd0;
          need_nxt   = 8'd0;
          reject_nxt = coin_any;
        end else if (coin_any) begin
          if (coin_fits) input_nxt = credit_sum[7:0];
          // One reject pulse covers the lower coins and/or a refused top coin.
          reject_nxt = coin_multi | ~coin_fits;
        end
      end

      VEND: begin
        reject_nxt = coin_any;
        state_nxt  = DISPENSE;
        gap_nxt    = 24'd0;
      end

      DISPENSE: begin
        reject_nxt = coin_any;
        if (change_money == 8'd0) begin
          state_nxt = IDLE;
          sel_nxt   = 2'd0;
          gap_nxt   = 24'd0;
        end else if (gap_cnt == GAP - 24'd1) begin
          disp_valid_nxt = 1'b1;
          disp_denom_nxt = pay_denom;
          change_nxt     = change_money - pay_val;
          gap_nxt        = 24'd0;
        end else begin
          gap_nxt = gap_cnt + 24'd1;
        end
      end

      default: begin
        // Unused encodings fall back to a clean idle machine.
        state_nxt      = IDLE;
        need_nxt       = 8'd0;
        input_nxt      = 8'd0;
        change_nxt     = 8'd0;
        sel_nxt        = 2'd0;
        disp_denom_nxt = 3'd0;
        gap_nxt        = 24'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      need_money   <= 8'd0;
      input_money  <= 8'd0;
      change_money <= 8'd0;
      goods_sel    <= 2'd0;
      vend_pulse   <= 1'b0;
      coin_reject  <= 1'b0;
      disp_valid   <= 1'b0;
      disp_denom   <= 3'd0;
      gap_cnt      <= 24'd0;
    end else begin
      state        <= state_nxt;
      need_money   <= need_nxt;
      input_money  <= input_nxt;
      change_money <= change_nxt;
      goods_sel    <= sel_nxt;
      vend_pulse   <= vend_nxt;
      coin_reject  <= reject_nxt;
      disp_valid   <= disp_valid_nxt;
      disp_denom   <= disp_denom_nxt;
      gap_cnt      <= gap_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: button/coin sequences with hand-computed
// money values, dispense denominations held in an expected queue.

module tb_vend_sequencer;

  localparam int GAP = 4;

  // ---------------------------------------------------------------- clock/reset
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       btn_goods = 0, btn_confirm = 0, btn_change = 0, btn_cancel = 0;
  logic       coin_one = 0, coin_five = 0, coin_ten = 0, coin_twenty = 0, coin_fifty = 0;
  logic [7:0] need_money, input_money, change_money;
  logic [1:0] goods_sel;
  logic       vend_pulse, coin_reject, disp_valid;
  logic [2:0] disp_denom, state_o;

  vend_sequencer #(
    .PRICE0(8'd3), .PRICE1(8'd5), .PRICE2(8'd12), .PRICE3(8'd25),
    .MAX_CREDIT(8'd99), .GAP(24'(GAP))
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .btn_goods(btn_goods), .btn_confirm(btn_confirm),
    .btn_change(btn_change), .btn_cancel(btn_cancel),
    .coin_one(coin_one), .coin_five(coin_five), .coin_ten(coin_ten),
    .coin_twenty(coin_twenty), .coin_fifty(coin_fifty),
    .need_money(need_money), .input_money(input_money),
    .change_money(change_money), .goods_sel(goods_sel),
    .vend_pulse(vend_pulse), .coin_reject(coin_reject),
    .disp_valid(disp_valid), .disp_denom(disp_denom), .state_o(state_o)
  );

  // ---------------------------------------------------------------- scoreboard
  int total = 0;
  int bad = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int denom_value(input logic [2:0] d);
    case (d)
      3'd0:    denom_value = 1;
      3'd1:    denom_value = 5;
      3'd2:    denom_value = 10;
      3'd3:    denom_value = 20;
      default: denom_value = 50;
    endcase
  endfunction

  // ---------------------------------------------------------------- drivers
  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // btn: [0]goods [1]confirm [2]change [3]cancel
  // coin: [0]one [1]five [2]ten [3]twenty [4]fifty
  task automatic drive(input logic [3:0] btn, input logic [4:0] coin);
    {btn_cancel, btn_change, btn_confirm, btn_goods} = btn;
    {coin_fifty, coin_twenty, coin_ten, coin_five, coin_one} = coin;
    tick();
    {btn_cancel, btn_change, btn_confirm, btn_goods} = 4'b0;
    {coin_fifty, coin_twenty, coin_ten, coin_five, coin_one} = 5'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_need"}, need_money, 0);
    chk({tag, "_input"}, input_money, 0);
    chk({tag, "_change"}, change_money, 0);
    chk({tag, "_sel"}, goods_sel, 0);
  endtask

  // Called with the DUT in its first DISPENSE cycle and change_money = start.
  task automatic run_dispense(input int n_pulse, input int start_change);
    int cyc, pulses, vends, exp_change;
    logic [2:0] d;
    bit done;
    cyc = 0; pulses = 0; vends = 0; done = 0;
    exp_change = start_change;
    chk("disp_start_change", change_money, start_change);
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      if (vend_pulse) vends++;
      if (disp_valid) begin
        pulses++;
        chk("disp_time", cyc, pulses * GAP);
        if (exp_q.size() == 0) begin
          chk("disp_extra", pulses, n_pulse);
        end else begin
          d = exp_q.pop_front();
          exp_change -= denom_value(d);
          chk("disp_denom", disp_denom, d);
          chk("disp_change", change_money, exp_change);
        end
      end
      if (state_o == 3'd0) done = 1;
    end
    chk("disp_reached_idle", done, 1);
    chk("disp_cycles", cyc, n_pulse * GAP + 1);
    chk("disp_count", pulses, n_pulse);
    chk("disp_vend", vends, 0);
    chk("disp_left", exp_q.size(), 0);
    chk_idle("post_disp");
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk_idle("reset");
    chk("reset_vend", vend_pulse, 0);
    chk("reset_reject", coin_reject, 0);
    chk("reset_disp", disp_valid, 0);
    chk("reset_denom", disp_denom, 0);
    sys_rst_n = 1'b1;
    tick();

    // IDLE: coin rejected, confirm ignored
    drive(4'b0000, 5'b00100);
    chk("idle_reject", coin_reject, 1);
    chk("idle_input", input_money, 0);
    drive(4'b0010, 5'b00000);
    chk("idle_confirm_ignored", state_o, 0);
    chk("idle_reject_clear", coin_reject, 0);

    // Normal purchase: item 2, pay 15, change 3 as three 1-coins
    drive(4'b0001, 5'b0);
    chk("sel_state", state_o, 1);
    chk("sel0_need", need_money, 3);
    chk("sel0_sel", goods_sel, 0);
    drive(4'b0001, 5'b0);
    chk("sel1_need", need_money, 5);
    drive(4'b0001, 5'b0);
    chk("sel2_need", need_money, 12);
    chk("sel2_sel", goods_sel, 2);
    drive(4'b0010, 5'b0);
    chk("pay_state", state_o, 2);
    drive(4'b0000, 5'b00100);
    chk("pay_ten", input_money, 10);
    chk("pay_ten_reject", coin_reject, 0);
    drive(4'b0000, 5'b00010);
    chk("pay_five", input_money, 15);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    drive(4'b0100, 5'b0);
    chk("vend_state", state_o, 3);
    chk("vend_pulse", vend_pulse, 1);
    chk("vend_sel", goods_sel, 2);
    chk("vend_change", change_money, 3);
    chk("vend_input", input_money, 0);
    chk("vend_need", need_money, 0);
    tick();
    chk("disp_enter", state_o, 4);
    chk("disp_vend_drop", vend_pulse, 0);
    run_dispense(3, 3);

    // Cancel refund of 37: 20,10,5,1,1
    drive(4'b0001, 5'b0);
    drive(4'b0010, 5'b0);
    drive(4'b0000, 5'b01000);
    drive(4'b0000, 5'b00100);
    drive(4'b0000, 5'b00010);
    drive(4'b0000, 5'b00001);
    drive(4'b0000, 5'b00001);
    chk("refund_input", input_money, 37);
    exp_q.push_back(3'd3); exp_q.push_back(3'd2); exp_q.push_back(3'd1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    drive(4'b1000, 5'b0);
    chk("refund_state", state_o, 4);
    chk("refund_vend", vend_pulse, 0);
    chk("refund_input0", input_money, 0);
    chk("refund_need0", need_money, 0);
    run_dispense(5, 37);

    // Credit limit: 95 + 5 refused, + 1 accepted
    drive(4'b0001, 5'b0);
    drive(4'b0010, 5'b0);
    drive(4'b0000, 5'b10000);
    drive(4'b0000, 5'b01000);
    drive(4'b0000, 5'b01000);
    drive(4'b0000, 5'b00010);
    chk("limit_95", input_money, 95);
    drive(4'b0000, 5'b00010);
    chk("limit_reject", coin_reject, 1);
    chk("limit_hold", input_money, 95);
    drive(4'b0000, 5'b00001);
    chk("limit_96", input_money, 96);
    chk("limit_no_reject", coin_reject, 0);
    drive(4'b0000, 5'b00001);
    drive(4'b0000, 5'b00001);
    drive(4'b0000, 5'b00001);
    chk("limit_99", input_money, 99);
    drive(4'b0000, 5'b00001);
    chk("limit_99_reject", coin_reject, 1);
    chk("limit_99_hold", input_money, 99);
    exp_q.push_back(3'd4); exp_q.push_back(3'd3); exp_q.push_back(3'd3);
    exp_q.push_back(3'd1); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    drive(4'b1000, 5'b0);
    run_dispense(8, 99);

    // Insufficient credit: item 3 (25), pay 20, change ignored, then exact pay
    repeat (4) drive(4'b0001, 5'b0);
    chk("sel3_sel", goods_sel, 3);
    chk("sel3_need", need_money, 25);
    drive(4'b0010, 5'b0);
    drive(4'b0000, 5'b01000);
    drive(4'b0100, 5'b0);
    chk("short_state", state_o, 2);
    chk("short_vend", vend_pulse, 0);
    chk("short_input", input_money, 20);
    drive(4'b0000, 5'b00010);
    drive(4'b0100, 5'b0);
    chk("exact_vend", vend_pulse, 1);
    chk("exact_sel", goods_sel, 3);
    chk("exact_change", change_money, 0);
    tick();
    chk("exact_disp", state_o, 4);
    run_dispense(0, 0);

    // Simultaneous coins, then cancel beats change
    drive(4'b0001, 5'b0);
    drive(4'b0010, 5'b0);
    drive(4'b0000, 5'b10100);
    chk("multi_input", input_money, 50);
    chk("multi_reject", coin_reject, 1);
    tick();
    chk("multi_reject_once", coin_reject, 0);
    exp_q.push_back(3'd4);
    drive(4'b1100, 5'b0);
    chk("prio_state", state_o, 4);
    chk("prio_vend", vend_pulse, 0);
    run_dispense(1, 50);

    // Reset mid-dispense: 70 refund, reset after the first 50 is paid
    drive(4'b0001, 5'b0);
    drive(4'b0010, 5'b0);
    drive(4'b0000, 5'b10000);
    drive(4'b0000, 5'b01000);
    drive(4'b1000, 5'b0);
    repeat (GAP) tick();
    chk("mid_disp_valid", disp_valid, 1);
    chk("mid_disp_denom", disp_denom, 4);
    chk("mid_disp_change", change_money, 20);
    tick();
    drive(4'b0000, 5'b00001);
    chk("mid_disp_reject", coin_reject, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_reject", coin_reject, 0);
    chk("async_rst_disp", disp_valid, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("after_rst_state", state_o, 0);
    drive(4'b0000, 5'b00001);
    chk("after_rst_reject", coin_reject, 1);
    chk("after_rst_input", input_money, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Central controller for the micro vending machine: sequences goods selection, coin acceptance, purchase and change dispensing. It consumes the single-cycle debounced pulses from the key filters and drives the three money values shown by the display block. Change is paid out one coin/note per pulse, largest denomination first.

Parameters:
PRICE0, 8'd3, price of item 0
PRICE1, 8'd5, price of item 1
PRICE2, 8'd12, price of item 2
PRICE3, 8'd25, price of item 3
MAX_CREDIT, 8'd99, maximum accepted credit (two display digits); must be <= 255
GAP, 24'd4, cycles between dispense pulses (board build overrides, e.g. 50_000_000)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
btn_goods  in  1  one-cycle pulse, step goods selection
btn_confirm  in  1  one-cycle pulse, confirm selection
btn_change  in  1  one-cycle pulse, pay and request change
btn_cancel  in  1  one-cycle pulse, abort transaction
coin_one, coin_five, coin_ten, coin_twenty, coin_fifty  in  1 each  one-cycle coin pulses
need_money  out  8  price of selected item, 0 when none
input_money  out  8  accumulated credit
change_money  out  8  change still owed
goods_sel  out  2  selected item index
vend_pulse  out  1  one-cycle pulse, item goods_sel released
coin_reject  out  1  one-cycle pulse, a coin was refused
disp_valid  out  1  one-cycle pulse, one denomination dispensed
disp_denom  out  3  0=1,1=5,2=10,3=20,4=50; valid with disp_valid
state_o  out  3  current state encoding

Behaviour:
- Clock and reset: single clock sys_clk; reset sys_rst_n is asynchronous and active-low.
- Reset: state IDLE; all money outputs 0, goods_sel 0, all pulses 0, disp_denom 0, gap counter 0. Reset asserted mid-transaction discards credit and change immediately.
- All outputs are registered. Every input pulse takes effect on the clock edge where it is sampled; the output change is visible in the next cycle.
- States and encodings: IDLE=0, SELECT=1, PAY=2, VEND=3, DISPENSE=4. Encodings 5-7 recover to IDLE.
- Button priority in the same cycle: cancel > change > confirm > goods.
- IDLE:
  - btn_goods -> SELECT; goods_sel=0; need=PRICE0.
  - Coins -> coin_reject pulse.
  - All other buttons are ignored.
- SELECT:
  - btn_goods -> goods_sel = (goods_sel+1) mod 4; need = PRICEn.
  - btn_confirm -> PAY.
  - btn_cancel -> IDLE, clearing need and goods_sel.
  - Coins -> coin_reject.
- PAY, coins:
  - Accepted coin: input += value. The sum is computed in 9 bits.
  - If input+value > MAX_CREDIT, the coin is refused: coin_reject pulses and input is unchanged.
  - Several coin pulses in one cycle: only the highest denomination is considered; coin_reject pulses once for the remainder.
- PAY, buttons:
  - btn_change with input >= need -> VEND.
  - btn_change with input < need is ignored; the block stays in PAY.
  - btn_cancel -> DISPENSE with change=input, input=0, need=0.
  - btn_goods and btn_confirm are ignored.
- VEND (exactly 1 cycle):
  - vend_pulse=1.
  - change = input-need; input=0; need=0.
  - -> DISPENSE.
- DISPENSE:
  - The gap counter starts at 0 on entry.
  - When change==0 -> IDLE (goods_sel cleared).
  - Otherwise, when the counter reaches GAP-1: disp_valid=1 for one cycle; disp_denom = largest of {50,20,10,5,1} <= change; change -= that value; counter returns to 0.
  - First pulse is GAP cycles after entry; consecutive pulses are GAP cycles apart.
  - All buttons, including cancel, are ignored; coins -> coin_reject.
- Exit timing: return to IDLE occurs one cycle after the change=0 update. change=0 on entry therefore gives DISPENSE for 1 cycle and no pulse.
- Invariant: change_money and input_money never exceed MAX_CREDIT, so no wrap-around is possible.

Test Plan:
- Normal purchase:
  - Stimulus: goods x3 -> need=12, goods_sel=2; confirm; coin_ten, coin_five -> input=15; change.
  - Required: vend_pulse with goods_sel=2; change=3; three disp_valid pulses, denom 0, GAP cycles apart; change 3->2->1->0; then IDLE with all outputs 0.
- Cancel refund:
  - Stimulus: in PAY with input=37, pulse btn_cancel.
  - Required: no vend_pulse; disp_denom sequence 3,2,1,0,0 (20,10,5,1,1); then IDLE.
- Credit limit:
  - Stimulus: input=95, coin_five; then coin_one.
  - Required: coin_reject with input staying 95; then input=96 with no reject.
- Insufficient credit:
  - Stimulus: need=25, input=20, btn_change.
  - Required: stays PAY, no vend_pulse. Then coin_five and btn_change -> vend; change=0; DISPENSE lasts 1 cycle -> IDLE.
- Simultaneous coins and priority:
  - Stimulus: coin_ten and coin_fifty in the same cycle in PAY.
  - Required: input += 50 and one coin_reject pulse.
  - Stimulus: btn_cancel and btn_change in the same cycle.
  - Required: cancel path taken.
- Reset mid-dispense:
  - Stimulus: assert sys_rst_n=0 asynchronously between disp pulses.
  - Required: all outputs 0 immediately; after release, IDLE and coins rejected.
